uart_frame_xcvr: RTL

Parametrised full-duplex UART frame transceiver for the ECS control link.
- Sends a TX_BYTES-byte frame from a parallel bus.
- Assembles RX_BYTES received bytes into a parallel frame, with framing-error and inter-byte-timeout detection.
- Replaces the fixed 4-TX/5-RX UART; sits between board logic and the RS-232/RS-485 transceiver.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_byte_rx.sv | 110 +++++++++++
 rtl/uart_frame_xcvr.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_pkg                                                     |
// | Description : Shared FSM state codes, timing helpers and the parity        |
// |               switch. Define UART_PARITY_EN for even parity on TX and RX.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package uart_pkg;

`ifdef UART_PARITY_EN
    localparam bit c_PARITY_EN = 1'b1;
`else
    localparam bit c_PARITY_EN = 1'b0;
`endif

    localparam int c_STATE_W = 3;

    // TX and RX walk the same character states
    localparam logic [c_STATE_W-1:0] c_ST_IDLE   = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_START  = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_DATA   = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_PARITY = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_STOP   = 3'd4;

    function automatic int calcDiv(input int clkHz, input int baud);
        return clkHz / baud;
    endfunction

    function automatic int cntWidth(input int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_byte_rx                                                 |
// | Description : Synchronised single-character receiver with mid-bit          |
// |               sampling; parity check when UART_PARITY_EN is defined.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int DIV = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_byteValid,
    output logic       o_err,
    output logic       o_idle
);

    localparam int              c_TW        = cntWidth(DIV);
    localparam logic [c_TW-1:0] c_BIT_LAST  = c_TW'(DIV - 1);
    localparam logic [c_TW-1:0] c_HALF_LAST = c_TW'(DIV / 2 - 1);

    logic [1:0]           r_sync;
    logic                 r_prev;
    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_stateNext;
    logic [c_TW-1:0]      r_timer;
    logic [2:0]           r_bitIdx;
    logic [7:0]           r_shift;
    logic                 r_parOk;
    logic                 w_rxs;
    logic                 w_fall;
    logic                 w_halfHit;
    logic                 w_bitHit;

    assign w_rxs     = r_sync[1];
    assign w_fall    = r_prev & ~w_rxs;
    assign w_halfHit = (r_timer == c_HALF_LAST);
    assign w_bitHit  = (r_timer == c_BIT_LAST);
    assign o_byte    = r_shift;
    assign o_idle    = (r_state == c_ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 2'b11;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], i_rx};
            r_prev <= w_rxs;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_stateNext;
    end

    // After the half-bit start sample, every later sample is one full bit apart
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_fall) w_stateNext = c_ST_START;
            c_ST_START:  if (w_halfHit) w_stateNext = w_rxs ? c_ST_IDLE : c_ST_DATA;
            c_ST_DATA:   if (w_bitHit && r_bitIdx == 3'd7)
                             w_stateNext = c_PARITY_EN ? c_ST_PARITY : c_ST_STOP;
            c_ST_PARITY: if (w_bitHit) w_stateNext = c_ST_STOP;
            c_ST_STOP:   if (w_bitHit) w_stateNext = c_ST_IDLE;
            default:     w_stateNext = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer     <= '0;
            r_bitIdx    <= 3'd0;
            r_shift     <= 8'd0;
            r_parOk     <= 1'b1;
            o_byteValid <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_byteValid <= 1'b0;
            o_err       <= 1'b0;
            if (r_state == c_ST_IDLE || w_stateNext != r_state || w_bitHit)
                r_timer <= '0;
            else
                r_timer <= r_timer + c_TW'(1);
            case (r_state)
                c_ST_START: begin
                    r_bitIdx <= 3'd0;
                    r_parOk  <= 1'b1;
                end
                c_ST_DATA: if (w_bitHit) begin
                    r_shift  <= {w_rxs, r_shift[7:1]};
                    r_bitIdx <= r_bitIdx + 3'd1;
                end
                c_ST_PARITY: if (w_bitHit) r_parOk <= (w_rxs == ^r_shift);
                c_ST_STOP: if (w_bitHit) begin
                    if (w_rxs && r_parOk) o_byteValid <= 1'b1;
                    else                  o_err       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_frame_xcvr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_frame_xcvr                                              |
// | Description : Full-duplex multi-byte UART frame transceiver with RX        |
// |               framing/timeout errors; UART_PARITY_EN adds even parity.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_frame_xcvr
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 25000000,
    parameter int BAUD         = 115200,
    parameter int TX_BYTES     = 4,
    parameter int RX_BYTES     = 5,
    parameter int IDLE_TO_BITS = 20
) (
    input  logic                  clk_25m,
    input  logic                  rst,
    input  logic                  uart_rx,
    output logic                  uart_tx,
    input  logic [TX_BYTES*8-1:0] tx_data,
    input  logic                  tx_start,
    output logic                  tx_busy,
    output logic                  tx_done,
    output logic [RX_BYTES*8-1:0] rx_data,
    output logic                  rx_rdy,
    output logic                  rx_err
);

    localparam int                c_DIV      = calcDiv(CLK_HZ, BAUD);
    localparam int                c_TW       = cntWidth(c_DIV);
    localparam int                c_GAP_MAX  = IDLE_TO_BITS * c_DIV;
    localparam int                c_GW       = cntWidth(c_GAP_MAX);
    localparam int                c_TXI_W    = cntWidth(TX_BYTES);
    localparam int                c_RXI_W    = cntWidth(RX_BYTES);
    localparam logic [c_TW-1:0]   c_BIT_LAST = c_TW'(c_DIV - 1);
    localparam logic [c_GW-1:0]   c_GAP_LAST = c_GW'(c_GAP_MAX - 1);

    logic [c_STATE_W-1:0]  r_txState;
    logic [c_STATE_W-1:0]  w_txNext;
    logic [c_TW-1:0]       r_txTimer;
    logic [2:0]            r_txBitIdx;
    logic [c_TXI_W-1:0]    r_txByteIdx;
    logic [TX_BYTES*8-1:0] r_txShadow;
    logic                  r_txPar;
    logic                  r_txLine;
    logic                  r_txDone;
    logic                  w_txBitHit;
    logic                  w_txLastByte;

    logic [7:0]            w_rxByte;
    logic                  w_rxByteValid;
    logic                  w_rxByteErr;
    logic                  w_rxIdle;
    logic [c_RXI_W-1:0]    r_rxIdx;
    logic [RX_BYTES*8-1:0] r_rxAsm;
    logic [RX_BYTES*8-1:0] w_asmNext;
    logic [RX_BYTES*8-1:0] r_rxData;
    logic [c_GW-1:0]       r_gap;
    logic                  r_rxRdy;
    logic                  r_rxErr;
    logic                  w_rxLast;
    logic                  w_gapHit;

    assign w_txBitHit   = (r_txTimer == c_BIT_LAST);
    assign w_txLastByte = (r_txByteIdx == c_TXI_W'(TX_BYTES - 1));
    assign uart_tx      = r_txLine;
    assign tx_busy      = (r_txState != c_ST_IDLE);
    assign tx_done      = r_txDone;

    always_ff @(posedge clk_25m) begin
        if (rst) r_txState <= c_ST_IDLE;
        else     r_txState <= w_txNext;
    end

    always_comb begin
        w_txNext = r_txState;
        case (r_txState)
            c_ST_IDLE:   if (tx_start) w_txNext = c_ST_START;
            c_ST_START:  if (w_txBitHit) w_txNext = c_ST_DATA;
            c_ST_DATA:   if (w_txBitHit && r_txBitIdx == 3'd7)
                             w_txNext = c_PARITY_EN ? c_ST_PARITY : c_ST_STOP;
            c_ST_PARITY: if (w_txBitHit) w_txNext = c_ST_STOP;
            c_ST_STOP:   if (w_txBitHit) w_txNext = w_txLastByte ? c_ST_IDLE : c_ST_START;
            default:     w_txNext = c_ST_IDLE;
        endcase
    end

    // Shadow shifts right once per data bit, so bit [0] is always the next bit out
    always_ff @(posedge clk_25m) begin
        if (rst) begin
            r_txTimer   <= '0;
            r_txBitIdx  <= 3'd0;
            r_txByteIdx <= '0;
            r_txShadow  <= '0;
            r_txPar     <= 1'b0;
            r_txLine    <= 1'b1;
            r_txDone    <= 1'b0;
        end else begin
            r_txDone <= 1'b0;
            if (r_txState == c_ST_IDLE || w_txBitHit)
                r_txTimer <= '0;
            else
                r_txTimer <= r_txTimer + c_TW'(1);
            case (r_txState)
                c_ST_IDLE: if (tx_start) begin
                    r_txShadow  <= tx_data;
                    r_txByteIdx <= '0;
                    r_txLine    <= 1'b0;
                end
                c_ST_START: if (w_txBitHit) begin
                    r_txLine   <= r_txShadow[0];
                    r_txBitIdx <= 3'd0;
                    r_txPar    <= 1'b0;
                end
                c_ST_DATA: if (w_txBitHit) begin
                    r_txShadow <= r_txShadow >> 1;
                    r_txPar    <= r_txPar ^ r_txShadow[0];
                    r_txBitIdx <= r_txBitIdx + 3'd1;
                    if (r_txBitIdx == 3'd7)
                        r_txLine <= c_PARITY_EN ? (r_txPar ^ r_txShadow[0]) : 1'b1;
                    else
                        r_txLine <= r_txShadow[1];
                end
                c_ST_PARITY: if (w_txBitHit) r_txLine <= 1'b1;
                c_ST_STOP: if (w_txBitHit) begin
                    if (w_txLastByte) begin
                        r_txDone <= 1'b1;
                    end else begin
                        r_txLine    <= 1'b0;
                        r_txByteIdx <= r_txByteIdx + c_TXI_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    uart_byte_rx #(
        .DIV (c_DIV)
    ) u_byteRx (
        .clk         (clk_25m),
        .rst         (rst),
        .i_rx        (uart_rx),
        .o_byte      (w_rxByte),
        .o_byteValid (w_rxByteValid),
        .o_err       (w_rxByteErr),
        .o_idle      (w_rxIdle)
    );

    assign w_rxLast = (r_rxIdx == c_RXI_W'(RX_BYTES - 1));
    assign w_gapHit = w_rxIdle && (r_rxIdx != '0) && (r_gap == c_GAP_LAST);
    assign rx_data  = r_rxData;
    assign rx_rdy   = r_rxRdy;
    assign rx_err   = r_rxErr;

    always_comb begin
        w_asmNext = r_rxAsm;
        for (int i = 0; i < RX_BYTES; i++) begin
            if (r_rxIdx == c_RXI_W'(i)) w_asmNext[i*8 +: 8] = w_rxByte;
        end
    end

    // Byte events and the gap timeout are mutually exclusive in time
    always_ff @(posedge clk_25m) begin
        if (rst) begin
            r_rxIdx  <= '0;
            r_rxAsm  <= '0;
            r_rxData <= '0;
            r_gap    <= '0;
            r_rxRdy  <= 1'b0;
            r_rxErr  <= 1'b0;
        end else begin
            r_rxRdy <= 1'b0;
            r_rxErr <= 1'b0;
            if (!w_rxIdle || r_rxIdx == '0 || w_gapHit)
                r_gap <= '0;
            else
                r_gap <= r_gap + c_GW'(1);
            if (w_rxByteValid) begin
                r_rxAsm <= w_asmNext;
                if (w_rxLast) begin
                    r_rxData <= w_asmNext;
                    r_rxRdy  <= 1'b1;
                    r_rxIdx  <= '0;
                end else begin
                    r_rxIdx <= r_rxIdx + c_RXI_W'(1);
                end
            end else if (w_rxByteErr || w_gapHit) begin
                r_rxErr <= 1'b1;
                r_rxIdx <= '0;
            end
        end
    end

endmodule
`default_nettype wire
